// File: rtl/cache_pkg.sv
// cache_pkg: shared widths, fill-state encoding and line type for the cache and its fill controller.
package cache_pkg;
    localparam int ADDR_W          = 15;
    localparam int WORD_W          = 32;
    localparam int WORDS_PER_BLOCK = 4;
    typedef enum logic [2:0] {IDLE, REQ, WAIT, FILL, DONE} fill_state_t;
    typedef logic [WORDS_PER_BLOCK*WORD_W-1:0] line_t;
endpackage

// File: rtl/cache_fill_ctrl_if.sv
// cache_fill_ctrl_if: CPU request, main-memory read and cache line-fill signals of the miss controller.
//   master: controller side (drives stall, mem_rd_en, mem_addr, fill_data, fill_we)
//   slave : CPU/cache/memory side (drives req_valid, req_addr, cache_miss, mem_rdata, mem_rvalid)
interface cache_fill_ctrl_if;
    import cache_pkg::*;
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              cache_miss;
    logic              stall;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_rdata;
    logic              mem_rvalid;
    line_t             fill_data;
    logic              fill_we;
    modport master (
        input  req_valid, req_addr, cache_miss, mem_rdata, mem_rvalid,
        output stall, mem_rd_en, mem_addr, fill_data, fill_we
    );
    modport slave (
        output req_valid, req_addr, cache_miss, mem_rdata, mem_rvalid,
        input  stall, mem_rd_en, mem_addr, fill_data, fill_we
    );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter that stops at all-ones.
//   clk, rst_n (async, active-low), en (count this cycle), count (current value)
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            count <= '0;
        else if (en && !(&count))
            count <= count + 1'b1;
endmodule

// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: stalls the CPU on a read miss, fetches the 4-word block word by word and strobes the line into the cache.
//   clk, rst_n (async, active-low)
//   bus        : request / memory / fill signals (master side)
//   hit_count  : saturating count of IDLE cycles with a hitting request
//   miss_count : saturating count of accepted misses
module cache_fill_ctrl
    import cache_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    cache_fill_ctrl_if.master bus,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);
    fill_state_t       state, state_d;
    logic [1:0]        k, k_d;
    logic [ADDR_W-3:0] base, base_d;
    logic              hit_en, miss_en;

    always_comb begin
        state_d   = state;
        k_d       = k;
        base_d    = base;
        hit_en    = 1'b0;
        miss_en   = 1'b0;
        bus.stall = 1'b1;
        case (state)
            IDLE: begin
                hit_en    = bus.req_valid & ~bus.cache_miss;
                miss_en   = bus.req_valid & bus.cache_miss;
                bus.stall = miss_en;
                if (miss_en) begin
                    state_d = REQ;
                    k_d     = 2'd0;
                    base_d  = bus.req_addr[ADDR_W-1:2];
                end
            end
            REQ:  state_d = WAIT;
            WAIT: if (bus.mem_rvalid) begin
                state_d = (k == 2'd3) ? FILL : REQ;
                k_d     = k + 2'd1;
            end
            FILL: state_d = DONE;
            default: begin
                state_d   = IDLE;
                bus.stall = 1'b0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state         <= IDLE;
            k             <= 2'd0;
            base          <= '0;
            bus.mem_rd_en <= 1'b0;
            bus.mem_addr  <= '0;
            bus.fill_we   <= 1'b0;
            bus.fill_data <= '0;
        end else begin
            state         <= state_d;
            k             <= k_d;
            base          <= base_d;
            bus.mem_rd_en <= state_d == REQ;
            bus.fill_we   <= state_d == FILL;
            if (state_d == REQ)
                bus.mem_addr <= {base_d, k_d};
            if (state == WAIT && bus.mem_rvalid)
                bus.fill_data[k*WORD_W +: WORD_W] <= bus.mem_rdata;
        end

    sat_counter #(.W(CNT_W)) u_hit  (.clk(clk), .rst_n(rst_n), .en(hit_en),  .count(hit_count));
    sat_counter #(.W(CNT_W)) u_miss (.clk(clk), .rst_n(rst_n), .en(miss_en), .count(miss_count));
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb_cache_fill_ctrl: randomized self-checking bench for cache_fill_ctrl against a cycle-schedule reference model.
module tb_cache_fill_ctrl;
    import cache_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] hit_count, miss_count;
    logic [1:0]  hit_s, miss_s;
    int          n_chk = 0;
    int          n_err = 0;
    int          m_hit = 0;
    int          m_miss = 0;
    line_t       m_line = '0;

    cache_fill_ctrl_if bus();
    cache_fill_ctrl_if bus_s();

    cache_fill_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.master),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    cache_fill_ctrl #(.CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .bus(bus_s.master),
        .hit_count(hit_s), .miss_count(miss_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic chk_cnt();
        chk("hit_count", hit_count, 128'(m_hit));
        chk("miss_count", miss_count, 128'(m_miss));
    endtask

    // One IDLE cycle: rv=1 is a hitting request, rv=0 no request; memory noise must be ignored.
    task automatic idle(input bit rv);
        @(negedge clk);
        bus.req_valid  = rv;
        bus.cache_miss = rv ? 1'b0 : 1'($urandom_range(0, 1));
        bus.req_addr   = 15'($urandom);
        bus.mem_rvalid = 1'($urandom_range(0, 1));
        bus.mem_rdata  = $urandom;
        #1;
        chk_cnt();
        chk("idle_stall", bus.stall, 0);
        chk("idle_rd_en", bus.mem_rd_en, 0);
        chk("idle_fill_we", bus.fill_we, 0);
        chk("idle_hold", bus.fill_data, m_line);
        if (rv && m_hit < 65535) m_hit++;
    endtask

    // Full miss: word i is requested in cycle r[i] and answered lat[i] cycles later;
    // the line is written the cycle after the last answer and DONE follows.
    task automatic miss_txn(input logic [14:0] a, input int lat[4], input logic [31:0] d[4],
                            input bit spur, input logic [14:0] alt);
        logic [14:0] base;
        int          r[4];
        int          fc;
        line_t       line;
        logic        exp_rd;
        logic [14:0] exp_ad;
        base = {a[14:2], 2'b00};
        r[0] = 1;
        for (int i = 1; i < 4; i++) r[i] = r[i-1] + 1 + lat[i-1];
        fc   = r[3] + lat[3] + 1;
        line = {d[3], d[2], d[1], d[0]};
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_addr   = a;
        bus.cache_miss = 1'b1;
        bus.mem_rvalid = 1'b0;
        #1;
        chk_cnt();
        chk("miss_stall", bus.stall, 1);
        if (m_miss < 65535) m_miss++;
        for (int c = 1; c <= fc + 1; c++) begin
            @(negedge clk);
            bus.req_valid  = 1'($urandom_range(0, 1));
            bus.cache_miss = 1'($urandom_range(0, 1));
            bus.req_addr   = alt;
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = $urandom;
            exp_rd = 1'b0;
            exp_ad = '0;
            for (int i = 0; i < 4; i++) begin
                if (c == r[i]) begin
                    exp_rd = 1'b1;
                    exp_ad = 15'(base + i);
                    if (spur) bus.mem_rvalid = 1'b1;
                end
                if (c == r[i] + lat[i]) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = d[i];
                end
            end
            #1;
            chk_cnt();
            chk("rd_en", bus.mem_rd_en, exp_rd);
            if (exp_rd) chk("mem_addr", bus.mem_addr, exp_ad);
            chk("fill_we", bus.fill_we, c == fc);
            if (c == fc) chk("fill_data", bus.fill_data, line);
            chk("stall", bus.stall, c <= fc);
        end
        m_line = line;
    endtask

    initial begin
        int          lat[4];
        logic [31:0] d[4];
        bus.req_valid    = 1'b0;
        bus.req_addr     = '0;
        bus.cache_miss   = 1'b0;
        bus.mem_rvalid   = 1'b0;
        bus.mem_rdata    = '0;
        bus_s.req_valid  = 1'b0;
        bus_s.req_addr   = '0;
        bus_s.cache_miss = 1'b0;
        bus_s.mem_rvalid = 1'b0;
        bus_s.mem_rdata  = '0;
        repeat (2) @(negedge clk);
        #1;
        chk_cnt();
        chk("rst_rd_en", bus.mem_rd_en, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_fill_we", bus.fill_we, 0);
        chk("rst_fill_data", bus.fill_data, 0);
        chk("rst_stall_lo", bus.stall, 0);
        bus.req_valid  = 1'b1;
        bus.cache_miss = 1'b1;
        #1 chk("rst_stall_hi", bus.stall, 1);
        bus.req_valid  = 1'b0;
        bus.cache_miss = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(0);
        // Directed miss at 0x0123, L=1, request address moves to 0x4000 mid-fetch.
        miss_txn(15'h0123, '{1, 1, 1, 1}, '{32'hA0, 32'hA1, 32'hA2, 32'hA3}, 1'b0, 15'h4000);
        idle(0);
        // Slow first word, spurious rvalid during every REQ.
        for (int i = 0; i < 4; i++) d[i] = $urandom;
        miss_txn(15'h0456, '{3, 1, 1, 1}, d, 1'b1, 15'h4000);
        // Three hits, a miss, then idle.
        repeat (3) idle(1);
        for (int i = 0; i < 4; i++) d[i] = $urandom;
        miss_txn(15'h7FFF, '{1, 2, 1, 4}, d, 1'b0, 15'h0000);
        idle(0);
        for (int t = 0; t < 20; t++) begin
            repeat ($urandom_range(0, 3)) idle(1'($urandom_range(0, 1)));
            for (int i = 0; i < 4; i++) begin
                lat[i] = $urandom_range(1, 4);
                d[i]   = $urandom;
            end
            miss_txn(15'($urandom), lat, d, 1'($urandom_range(0, 1)), 15'($urandom));
        end
        idle(0);
        // Reset during WAIT of word 2 (L=1: REQ w2 in cycle 5, WAIT in cycle 6).
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.cache_miss = 1'b1;
        bus.req_addr   = 15'h2345;
        bus.mem_rvalid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            bus.req_valid  = 1'b0;
            bus.cache_miss = 1'b0;
            bus.mem_rvalid = (c == 2 || c == 4);
            bus.mem_rdata  = $urandom | 32'h1;
        end
        #2 rst_n = 1'b0;
        bus.req_valid  = 1'b1;
        bus.cache_miss = 1'b1;
        bus.mem_rvalid = 1'b0;
        m_hit  = 0;
        m_miss = 0;
        m_line = '0;
        #1;
        chk_cnt();
        chk("mid_rst_fill_we", bus.fill_we, 0);
        chk("mid_rst_fill_data", bus.fill_data, 0);
        chk("mid_rst_rd_en", bus.mem_rd_en, 0);
        chk("mid_rst_mem_addr", bus.mem_addr, 0);
        chk("mid_rst_stall_hi", bus.stall, 1);
        bus.cache_miss = 1'b0;
        #1 chk("mid_rst_stall_lo", bus.stall, 0);
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) idle(0);
        // Saturation on a 2-bit instance: 2 hits reach all-ones-minus-one, 3 more must stick at all-ones.
        @(negedge clk);
        bus_s.req_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            #1;
            chk("sat_hit", hit_s, (i > 3) ? 3 : i);
            chk("sat_miss", miss_s, 0);
        end
        bus_s.req_valid = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
